cp0_intc: RTL and testbench

Parametrised coprocessor-0 and interrupt controller for the five-stage MIPS pipeline. It succeeds the fixed six-line CP0 with the following changes:
- `NUM_HWINT` hardware interrupt lines.
- Per-line level or edge mode, with edge-pending latches and write-1-to-clear acknowledge.
- Synchronous exception entry alongside interrupts.
- Branch-delay-slot EPC correction.

It sits beside the M stage. The datapath uses `take_exc` to flush F/D/E/M/W and load `handler_pc`, and uses `epc` for ERET.

---
 rtl/cp0_intc_if.sv | 9 +
 rtl/cp0_intc.sv | 88 ++++++++
 tb/tb_cp0_intc.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_intc_if.sv
// cp0_intc_if: mfc0/mtc0 register bus between the M stage and CP0
interface cp0_intc_if;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output addr, we, wdata, input rdata);
    modport slave (input addr, we, wdata, output rdata);
endinterface

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 registers and level/edge interrupt controller for the MIPS pipeline
module cp0_intc #(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter logic [31:0] PRID      = 32'h0000_0007
) (
    input  logic                 clk,
    input  logic                 reset,
    cp0_intc_if.slave            bus,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 exc_req,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_bd,
    input  logic                 eret,
    output logic                 int_req,
    output logic                 take_exc,
    output logic [31:0]          handler_pc,
    output logic [31:0]          epc,
    output logic                 exl
);
    localparam int N = NUM_HWINT;
    logic [N-1:0] im_q, im_d, mode_q, mode_d, pend_q, pend_d, hw_s_q, hw_d_q;
    logic [N-1:0] rise, ack, ip;
    logic         exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, wr;
    logic [4:0]   code_q, code_d;
    logic [31:0]  epc_q, epc_d, epc_src, sr, cause;
    always_comb begin
        // a fresh edge counts as pending in the cycle it is seen, before pend_q catches it
        rise     = hw_s_q & ~hw_d_q;
        ip       = (mode_q & (pend_q | rise)) | (~mode_q & hw_s_q);
        int_req  = ie_q & ~exl_q & |(ip & im_q);
        take_exc = ~exl_q & (int_req | exc_req);
        wr       = bus.we & ~take_exc;
        ack      = (wr && bus.addr == 5'd23) ? bus.wdata[N-1:0] : '0;
        epc_src  = exc_bd ? exc_pc - 32'd4 : exc_pc;
        sr             = '0;
        sr[N+9:10]     = im_q;
        sr[1]          = exl_q;
        sr[0]          = ie_q;
        cause          = '0;
        cause[31]      = bd_q;
        cause[N+9:10]  = ip;
        cause[6:2]     = code_q;
        im_d   = (wr && bus.addr == 5'd12) ? bus.wdata[N+9:10] : im_q;
        ie_d   = (wr && bus.addr == 5'd12) ? bus.wdata[0] : ie_q;
        exl_d  = take_exc ? 1'b1 : eret ? 1'b0 : (wr && bus.addr == 5'd12) ? bus.wdata[1] : exl_q;
        bd_d   = take_exc ? exc_bd : bd_q;
        code_d = take_exc ? (int_req ? 5'd0 : exc_code) : code_q;
        epc_d  = take_exc ? epc_src & 32'hFFFF_FFFC
               : (wr && bus.addr == 5'd14) ? bus.wdata & 32'hFFFF_FFFC : epc_q;
        mode_d = (wr && bus.addr == 5'd22) ? bus.wdata[N-1:0] : mode_q;
        pend_d = (pend_q & ~ack) | (mode_q & rise);
        bus.rdata = bus.addr == 5'd12 ? sr
                  : bus.addr == 5'd13 ? cause
                  : bus.addr == 5'd14 ? epc_q
                  : bus.addr == 5'd15 ? PRID
                  : bus.addr == 5'd22 ? 32'(mode_q) : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q   <= '0;
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            bd_q   <= 1'b0;
            code_q <= '0;
            epc_q  <= '0;
            mode_q <= '0;
            pend_q <= '0;
            hw_s_q <= '0;
            hw_d_q <= '0;
        end else begin
            im_q   <= im_d;
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            bd_q   <= bd_d;
            code_q <= code_d;
            epc_q  <= epc_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            hw_s_q <= hwint;
            hw_d_q <= hw_s_q;
        end
    end
    assign handler_pc = EXC_VEC;
    assign epc        = epc_q;
    assign exl        = exl_q;
endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed vectors for cp0_intc built with 16 interrupt lines
module tb_cp0_intc;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] hwint;
    logic        exc_req, exc_bd, eret, int_req, take_exc, exl;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, handler_pc, epc;
    int          n_vec = 0;
    int          n_err = 0;
    cp0_intc_if bus();
    cp0_intc #(.NUM_HWINT(16)) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .hwint(hwint),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .eret(eret), .int_req(int_req), .take_exc(take_exc),
        .handler_pc(handler_pc), .epc(epc), .exl(exl)
    );
    always #50 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick;
        bus.we    = 1'b0;
    endtask
    task automatic do_eret;
        eret = 1'b1;
        tick;
        eret = 1'b0;
        #1;
    endtask
    initial begin
        reset = 1'b0; hwint = 16'hFFFF; exc_req = 1'b0; exc_bd = 1'b0; eret = 1'b0;
        exc_code = 5'd0; exc_pc = 32'd0;
        bus.addr = 5'd0; bus.we = 1'b0; bus.wdata = 32'd0;
        tick; tick;
        rd(5'd12, "rst_sr", 32'h0);
        rd(5'd13, "rst_cause", 32'h0);
        rd(5'd14, "rst_epc", 32'h0);
        rd(5'd15, "rst_prid", 32'h7);
        rd(5'd22, "rst_mode", 32'h0);
        chk("rst_int_req", int_req, 1'b0);
        chk("rst_take", take_exc, 1'b0);
        chk("rst_exl", exl, 1'b0);
        chk("handler_pc", handler_pc, 32'h0000_4180);
        reset = 1'b1; hwint = 16'h0;
        tick; tick;
        chk("idle_int_req", int_req, 1'b0);
        wr(5'd12, 32'h0000_0401);
        exc_pc = 32'h0000_3010;
        hwint = 16'h0001;
        #1;
        chk("lvl_pre_take", take_exc, 1'b0);
        tick;
        chk("lvl_int_req", int_req, 1'b1);
        chk("lvl_take", take_exc, 1'b1);
        tick;
        chk("lvl_exl", exl, 1'b1);
        chk("lvl_epc", epc, 32'h0000_3010);
        rd(5'd13, "lvl_cause", 32'h0000_0400);
        rd(5'd12, "lvl_sr", 32'h0000_0403);
        chk("lvl_masked", take_exc, 1'b0);
        eret = 1'b1;
        #1;
        chk("eret_no_take", take_exc, 1'b0);
        tick;
        eret = 1'b0;
        #1;
        chk("eret_exl", exl, 1'b0);
        chk("lvl_reentry", take_exc, 1'b1);
        tick;
        chk("reentry_exl", exl, 1'b1);
        hwint = 16'h0;
        do_eret;
        chk("lvl_quiet_exl", exl, 1'b0);
        chk("lvl_quiet_take", take_exc, 1'b0);
        hwint = 16'h0001; exc_pc = 32'h0000_3040;
        tick;
        eret = 1'b1; bus.addr = 5'd14; bus.wdata = 32'hDEAD_BEE0; bus.we = 1'b1;
        #1;
        chk("simul_take", take_exc, 1'b1);
        tick;
        eret = 1'b0; bus.we = 1'b0;
        #1;
        chk("eret_vs_take_exl", exl, 1'b1);
        chk("we_discard_epc", epc, 32'h0000_3040);
        hwint = 16'h0;
        do_eret;
        wr(5'd12, 32'h0000_0403);
        chk("mtc0_exl", exl, 1'b1);
        hwint = 16'h0001;
        tick;
        chk("exl_mask_int", int_req, 1'b0);
        chk("exl_mask_take", take_exc, 1'b0);
        wr(5'd12, 32'h0000_0401);
        chk("unmask_take", take_exc, 1'b1);
        tick;
        chk("unmask_exl", exl, 1'b1);
        hwint = 16'h0;
        do_eret;
        bus.addr = 5'd14; bus.wdata = 32'h1234_5677; bus.we = 1'b1;
        #1;
        chk("rd_old_epc", bus.rdata, 32'h0000_3040);
        tick;
        bus.we = 1'b0;
        rd(5'd14, "epc_write", 32'h1234_5674);
        wr(5'd22, 32'h0000_0004);
        wr(5'd12, 32'h0000_1001);
        rd(5'd22, "mode_rd", 32'h0000_0004);
        hwint = 16'h0004;
        tick;
        hwint = 16'h0;
        #1;
        chk("edge_int_req", int_req, 1'b1);
        chk("edge_take", take_exc, 1'b1);
        tick;
        chk("edge_exl", exl, 1'b1);
        rd(5'd13, "edge_ip_held", 32'h0000_1000);
        do_eret;
        chk("edge_pending_reentry", take_exc, 1'b1);
        tick;
        wr(5'd23, 32'h0000_0004);
        rd(5'd23, "ack_rd", 32'h0);
        rd(5'd13, "ack_ip_clr", 32'h0);
        do_eret;
        chk("ack_exl", exl, 1'b0);
        chk("ack_no_take", take_exc, 1'b0);
        exc_req = 1'b1; exc_code = 5'd12; exc_pc = 32'h0000_3024; exc_bd = 1'b1;
        #1;
        chk("bd_take", take_exc, 1'b1);
        tick;
        exc_req = 1'b0; exc_bd = 1'b0;
        #1;
        chk("bd_epc", epc, 32'h0000_3020);
        rd(5'd13, "bd_cause", 32'h8000_0030);
        rd(5'd12, "bd_sr", 32'h0000_1003);
        do_eret;
        wr(5'd12, 32'h0000_0401);
        hwint = 16'h0001;
        tick;
        exc_req = 1'b1; exc_code = 5'd12; exc_pc = 32'h0000_3050;
        tick;
        exc_req = 1'b0;
        rd(5'd13, "int_beats_exc", 32'h0000_0400);
        chk("int_exc_epc", epc, 32'h0000_3050);
        hwint = 16'h0;
        do_eret;
        wr(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, "sr_fields", 32'h03FF_FC03);
        wr(5'd12, 32'h0200_0001);
        hwint = 16'h8000;
        tick;
        rd(5'd13, "line15_ip", 32'h0200_0000);
        chk("line15_take", take_exc, 1'b1);
        tick;
        chk("line15_exl", exl, 1'b1);
        wr(5'd22, 32'hFFFF_FFFF);
        rd(5'd22, "mode_fields", 32'h0000_FFFF);
        reset = 1'b0;
        tick;
        reset = 1'b1; hwint = 16'h0;
        #1;
        chk("midrst_exl", exl, 1'b0);
        chk("midrst_epc", epc, 32'h0);
        chk("midrst_int_req", int_req, 1'b0);
        rd(5'd22, "midrst_mode", 32'h0);
        rd(5'd15, "midrst_prid", 32'h7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
